stopwatch_display_scan: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 37 +++
 rtl/bcd_to_seg7.sv | 17 +
 rtl/stopwatch_display_scan.sv | 161 ++++++++++++++++
 tb/tb_stopwatch_display_scan.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and 7-segment constants for the stopwatch display path.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-low.
package stopwatch_pkg;

  typedef logic [6:0] seg7_t;
  typedef logic [1:0] digit_idx_t;

  typedef enum logic {
    S_GUARD,
    S_DRIVE
  } slot_state_e;

  localparam seg7_t SEG_BLANK = 7'h7F;
  localparam seg7_t SEG_DASH  = 7'b0111111;

  localparam seg7_t SEG_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  function automatic logic [3:0] nibble_sel(input logic [15:0] v, input digit_idx_t idx);
    return v[{idx, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] anode_low(input digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment decoder.
// Codes above 9 render as a dash so corrupted time values stay visible.
module bcd_to_seg7
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd,
  output seg7_t      seg
);

  always_comb begin
    seg = SEG_DASH;
    for (int i = 0; i < 10; i++) begin
      if (bcd == 4'(i)) seg = SEG_DIGIT[i];
    end
  end

endmodule

// File: rtl/stopwatch_display_scan.sv
// Frame-synchronous 4-digit multiplexed 7-segment scanner for an MM:SS BCD time.
// Optional colon blink gated by RUN is enabled with the COLON_BLINK_EN macro.
module stopwatch_display_scan
  import stopwatch_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD        = 16,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] T,
  input  logic        UPD,
  input  logic        LZ,
  input  logic        RUN,
  output logic [6:0]  SEG,
  output logic [3:0]  AN,
  output logic        DP,
  output logic        FRAME
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_LAST   = cnt_t'(REFRESH_DIV - 1);
  localparam cnt_t GUARD_LAST = cnt_t'(GUARD - 1);

  cnt_t        cnt_q, cnt_d;
  digit_idx_t  idx_q, idx_d;
  slot_state_e state_q, state_d;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] disp_q, disp_d;
  logic        pend_q, pend_d;
  seg7_t       seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  logic        dp_q, dp_d;
  logic        frame_q, frame_d;

  logic        slot_end, boundary, colon_on;
  logic [3:0]  cur_nibble;
  seg7_t       dec_seg;

  assign slot_end   = (cnt_q == CNT_LAST);
  assign boundary   = slot_end && (idx_q == 2'd3);
  assign cur_nibble = nibble_sel(disp_q, idx_q);

  bcd_to_seg7 u_dec (
    .bcd (cur_nibble),
    .seg (dec_seg)
  );

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    cnt_d    = slot_end ? '0 : cnt_q + cnt_t'(1);
    idx_d    = slot_end ? idx_q + 2'd1 : idx_q;
    state_d  = state_q;
    shadow_d = shadow_q;
    disp_d   = disp_q;
    pend_d   = pend_q;
    frame_d  = 1'b0;
    seg_d    = SEG_BLANK;
    an_d     = 4'hF;
    dp_d     = 1'b1;

    case (state_q)
      S_GUARD: if (cnt_q == GUARD_LAST) state_d = S_DRIVE;
      S_DRIVE: if (slot_end) state_d = S_GUARD;
      default: state_d = S_GUARD;
    endcase

    // The boundary reload uses the old shadow; a coincident UPD re-arms pend afterwards.
    if (boundary && pend_q) begin
      disp_d  = shadow_q;
      pend_d  = 1'b0;
      frame_d = 1'b1;
    end
    if (UPD) begin
      shadow_d = T;
      pend_d   = 1'b1;
    end

    if (state_q == S_DRIVE) begin
      an_d  = anode_low(idx_q);
      seg_d = (LZ && idx_q == 2'd3 && cur_nibble == 4'd0) ? SEG_BLANK : dec_seg;
      dp_d  = !(idx_q == 2'd2 && colon_on);
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (RST) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      state_q  <= S_GUARD;
      shadow_q <= '0;
      disp_q   <= '0;
      pend_q   <= 1'b0;
      seg_q    <= SEG_BLANK;
      an_q     <= 4'hF;
      dp_q     <= 1'b1;
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      state_q  <= state_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      dp_q     <= dp_d;
      frame_q  <= frame_d;
    end
  end

`ifdef COLON_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  typedef logic [FC_W-1:0] fcnt_t;
  localparam fcnt_t FC_LAST = fcnt_t'(BLINK_FRAMES - 1);

  fcnt_t fcnt_q, fcnt_d;
  logic  blink_q, blink_d;

  always_comb begin
    fcnt_d  = fcnt_q;
    blink_d = blink_q;
    if (!RUN) begin
      fcnt_d  = '0;
      blink_d = 1'b1;
    end else if (boundary) begin
      if (fcnt_q == FC_LAST) begin
        fcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        fcnt_d = fcnt_q + fcnt_t'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fcnt_q  <= '0;
      blink_q <= 1'b1;
    end else begin
      fcnt_q  <= fcnt_d;
      blink_q <= blink_d;
    end
  end

  assign colon_on = blink_q;
`else
  logic unused_run;
  assign unused_run = RUN | (BLINK_FRAMES < 1);
  assign colon_on   = 1'b1;
`endif

  assign SEG   = seg_q;
  assign AN    = an_q;
  assign DP    = dp_q;
  assign FRAME = frame_q;

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Scoreboard bench for stopwatch_display_scan with a short refresh divider.
// Expected display values are queued at UPD time and checked after each FRAME pulse.
module tb_stopwatch_display_scan;

  localparam int RD        = 8;
  localparam int GD        = 2;
  localparam int BF        = 2;
  localparam int FRAME_CYC = 4 * RD;

  typedef struct {
    logic [15:0] t;
    logic        lz;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] T   = '0;
  logic        UPD = 1'b0;
  logic        LZ  = 1'b0;
  logic        RUN = 1'b0;
  logic [6:0]  SEG;
  logic [3:0]  AN;
  logic        DP;
  logic        FRAME;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t exp_q[$];

  stopwatch_display_scan #(
    .REFRESH_DIV  (RD),
    .GUARD        (GD),
    .BLINK_FRAMES (BF)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .T     (T),
    .UPD   (UPD),
    .LZ    (LZ),
    .RUN   (RUN),
    .SEG   (SEG),
    .AN    (AN),
    .DP    (DP),
    .FRAME (FRAME)
  );

  always #5 CLK = ~CLK;

  // Edges since reset release; a sample after edge k reflects slot position k-1.
  always @(posedge CLK) cyc <= RST ? 0 : cyc + 1;

  always @(negedge CLK) begin
    if (!RST) begin
      checks++;
      assert ($countones(~AN) <= 1)
      else begin
        errors++;
        $display("FAIL anode_overlap AN=%b allowed at most one low anode", AN);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] exp_seg(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [3:0] exp_an(input int s);
    case (s)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  task automatic tick_upd(input logic [15:0] val);
    T   = val;
    UPD = 1'b1;
    @(negedge CLK);
    UPD = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    for (int n = 0; n <= FRAME_CYC; n++) begin
      if (cyc % FRAME_CYC == ph) return;
      @(negedge CLK);
    end
    checks++;
    errors++;
    $display("FAIL wait_phase_timeout phase=%0d cyc=%0d", ph, cyc);
  endtask

  task automatic wait_frame(input string tag);
    for (int n = 0; n < 3 * FRAME_CYC; n++) begin
      @(negedge CLK);
      if (FRAME === 1'b1) break;
    end
    checks++;
    if (FRAME !== 1'b1) begin
      errors++;
      $display("FAIL %s_frame_timeout FRAME=%b required 1 within %0d cycles", tag, FRAME, 3 * FRAME_CYC);
    end
  endtask

  task automatic verify_frame(input string tag);
    exp_t        e;
    int          extra;
    int          s;
    logic [3:0]  nib;
    logic [11:0] exp_v;
    extra = 0;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard_empty size=0 required >0", tag);
      return;
    end
    e = exp_q.pop_front();
    for (int j = 0; j < FRAME_CYC; j++) begin
      @(negedge CLK);
      if (FRAME !== 1'b0) extra++;
      if (j % RD == 4) begin
        s     = j / RD;
        nib   = e.t[4*s +: 4];
        exp_v = {exp_an(s),
                 (e.lz && s == 3 && nib == 4'd0) ? 7'h7F : exp_seg(nib),
                 (s == 2) ? 1'b0 : 1'b1};
        checks++;
        if ({AN, SEG, DP} !== exp_v) begin
          errors++;
          $display("FAIL %s_slot%0d AN/SEG/DP=%b/%b/%b required %b/%b/%b", tag, s,
                   AN, SEG, DP, exp_v[11:8], exp_v[7:1], exp_v[0]);
        end
      end
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL %s_frame_once extra_pulses=%0d required 0", tag, extra);
    end
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST = 1'b1;
    UPD = 1'b0;
    T   = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    LZ  = 1'b0;
    RUN = 1'b0;
    apply_reset();
    checks++;
    if (SEG !== 7'h7F) begin errors++; $display("FAIL reset_seg SEG=%h required 7f", SEG); end
    checks++;
    if (AN !== 4'hF) begin errors++; $display("FAIL reset_an AN=%b required 1111", AN); end
    checks++;
    if (DP !== 1'b1) begin errors++; $display("FAIL reset_dp DP=%b required 1", DP); end
    checks++;
    if (FRAME !== 1'b0) begin errors++; $display("FAIL reset_frame FRAME=%b required 0", FRAME); end
    RST = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      @(negedge CLK);
      checks++;
      if (n < 3) begin
        if (AN !== 4'hF) begin
          errors++;
          $display("FAIL reset_guard%0d AN=%b required 1111", n, AN);
        end
      end else if (AN !== 4'b1110 || SEG !== 7'b1000000) begin
        errors++;
        $display("FAIL reset_first_drive AN=%b SEG=%b required 1110 1000000", AN, SEG);
      end
    end
  endtask

  task automatic test_update();
    exp_q.push_back('{16'h1259, 1'b0});
    tick_upd(16'h1259);
    wait_phase(13);
    checks++;
    if (AN !== 4'b1101 || SEG !== 7'b1000000) begin
      errors++;
      $display("FAIL update_no_tear AN=%b SEG=%b required 1101 1000000", AN, SEG);
    end
    wait_frame("update");
    verify_frame("update");
  endtask

  task automatic test_back_to_back();
    int bnd;
    wait_phase(2);
    tick_upd(16'h0001);
    tick_upd(16'h0002);
    exp_q.push_back('{16'h0002, 1'b0});
    wait_frame("last_wins");
    verify_frame("last_wins");

    wait_phase(FRAME_CYC - 1);
    exp_q.push_back('{16'h0037, 1'b0});
    tick_upd(16'h0037);
    bnd = cyc;
    checks++;
    if (FRAME !== 1'b0) begin
      errors++;
      $display("FAIL race_no_reload FRAME=%b required 0", FRAME);
    end
    wait_phase(5);
    checks++;
    if (AN !== 4'b1110 || SEG !== exp_seg(4'd2)) begin
      errors++;
      $display("FAIL race_old_value AN=%b SEG=%b required 1110 %b", AN, SEG, exp_seg(4'd2));
    end
    wait_frame("race_boundary");
    checks++;
    if (cyc != bnd + FRAME_CYC) begin
      errors++;
      $display("FAIL race_reload_time cyc=%0d required %0d", cyc, bnd + FRAME_CYC);
    end
    verify_frame("race_boundary");
  endtask

  task automatic test_lz_dash();
    LZ = 1'b1;
    exp_q.push_back('{16'h0A07, 1'b1});
    tick_upd(16'h0A07);
    wait_frame("lz_dash");
    verify_frame("lz_dash");
    LZ = 1'b0;
  endtask

  task automatic test_guard();
    int j;
    int c;
    int s;
    for (int n = 0; n < FRAME_CYC; n++) begin
      @(negedge CLK);
      j = (cyc - 1) % FRAME_CYC;
      c = j % RD;
      s = j / RD;
      checks++;
      if (c < GD) begin
        if (AN !== 4'hF || SEG !== 7'h7F || DP !== 1'b1) begin
          errors++;
          $display("FAIL guard_slot%0d_c%0d AN=%b SEG=%b DP=%b required 1111 1111111 1", s, c, AN, SEG, DP);
        end
      end else if (AN !== exp_an(s) || DP !== (s != 2)) begin
        errors++;
        $display("FAIL drive_slot%0d_c%0d AN=%b DP=%b required %b %b", s, c, AN, DP, exp_an(s), s != 2);
      end
    end
  endtask

  task automatic test_reset_mid();
    wait_phase(10);
    tick_upd(16'h4321);
    apply_reset();
    RST = 1'b0;
    for (int n = 1; n <= FRAME_CYC + 5; n++) begin
      @(negedge CLK);
      if (n == FRAME_CYC) begin
        checks++;
        if (FRAME !== 1'b0) begin
          errors++;
          $display("FAIL reset_mid_pending FRAME=%b required 0", FRAME);
        end
      end
      if (n == FRAME_CYC + 5) begin
        checks++;
        if (AN !== 4'b1110 || SEG !== 7'b1000000) begin
          errors++;
          $display("FAIL reset_mid_disp AN=%b SEG=%b required 1110 1000000", AN, SEG);
        end
      end
    end
  endtask

  task automatic test_colon_blink();
    int   f;
    logic lit;
    apply_reset();
    RST = 1'b0;
    RUN = 1'b1;
    for (int n = 1; n <= 7 * FRAME_CYC; n++) begin
      @(negedge CLK);
      if ((n - 1) % FRAME_CYC == 2 * RD + 4) begin
        f = (n - 1) / FRAME_CYC;
`ifdef COLON_BLINK_EN
        lit = (f >= 5) || ((f / BF) % 2 == 0);
`else
        lit = 1'b1;
`endif
        checks++;
        if (DP !== !lit) begin
          errors++;
          $display("FAIL colon_frame%0d DP=%b required %b", f, DP, !lit);
        end
      end
      if (n == 5 * FRAME_CYC) RUN = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_update();
    test_back_to_back();
    test_lz_dash();
    test_guard();
    test_reset_mid();
    test_colon_blink();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
